// File: rtl/nios2_debug_ocimem_ctrl.sv
// nios2_debug_ocimem_ctrl
//
// Debug-memory access engine for the Nios II debug slave. It owns a
// 2^ADDR_W x 32 on-chip debug RAM. Two sources share that RAM:
// JTAG-initiated commands and an Avalon-MM CPU slave. A single arbiter FSM
// serialises them, and JTAG always has priority over the CPU.
//
// JTAG commands arrive as one-cycle pulses, with their payload on jdo. JTAG
// read data and status are returned on MonDReg, monitor_ready and
// monitor_error.
//
// Ports:
//   clk, reset               system clock; synchronous active-high reset
//   take_action_ocimem_a     pulse: load address from jdo, optional read (jdo[35])
//   take_no_action_ocimem_a  pulse: read continuation at the current address
//   take_action_ocimem_b     pulse: write jdo[34:3] at the current address
//   jdo[37:0]                JTAG payload
//   MonDReg[31:0]            last JTAG read data
//   monitor_ready            JTAG command completed
//   monitor_error            sticky: a JTAG command was dropped
//   address, read, write,    Avalon-MM slave (word addressed), with writes
//   writedata, byteenable,   qualified by debugaccess
//   debugaccess, readdata,
//   waitrequest
module nios2_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_JTAG_RD = 2'd1,
    ST_CPU_RD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_ADDR  = 2'd0,
    CMD_CONT  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_t;

  state_t            state;
  cmd_t              jcmd;
  logic              jtag_pend;
  logic              jrd;
  logic [ADDR_W-1:0] jaddr;
  logic [31:0]       jwdata;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic [31:0]       ram_q;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;

  logic              pulse_any;
  logic              pulse_accept;
  logic              jtag_is_rd;
  logic              cpu_go;

  // Only the read flag, the address field and the write-data field of jdo
  // carry meaning here.
  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // A new JTAG command is accepted only while nothing is outstanding.
  // A pulse that lands while a command is still pending, or while a JTAG
  // read is in flight, has nowhere to go. Such a pulse is dropped.
  always_comb begin
    pulse_any    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    pulse_accept = pulse_any && !jtag_pend && (state != ST_JTAG_RD);
    jtag_is_rd   = jtag_pend && ((jcmd == CMD_CONT) || ((jcmd == CMD_ADDR) && jrd));
    cpu_go       = (state == ST_IDLE) && !jtag_pend;
  end

  // RAM port control.
  // A pending JTAG command owns the port in IDLE. The CPU gets the port
  // only when no JTAG command is pending. A simultaneous read and write is
  // treated as a read. Writes are suppressed during reset, so that an
  // aborted cycle leaves no trace in memory.
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = address;
    ram_we    = 4'h0;
    ram_waddr = address;
    ram_wdata = writedata;
    if (state == ST_IDLE && jtag_pend) begin
      ram_raddr = jaddr;
      ram_waddr = jaddr;
      ram_wdata = jwdata;
      if (jtag_is_rd)
        ram_re = 1'b1;
      else if (jcmd == CMD_WRITE)
        ram_we = 4'hF;
    end else if (cpu_go) begin
      if (read)
        ram_re = 1'b1;
      else if (write && debugaccess)
        ram_we = byteenable;
    end
    if (reset)
      ram_we = 4'h0;
  end

  // Debug RAM: byte-lane writes and a registered read port (1-cycle latency).
  // Contents are intentionally left untouched by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i])
        ram[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    if (ram_re)
      ram_q <= ram[ram_raddr];
  end

  // Arbiter FSM and JTAG command/status registers.
  // The FSM only touches jaddr, jtag_pend and monitor_ready while a command
  // is pending. The latch block below only acts when none is pending.
  // So the two never contend for the same register in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      jcmd          <= CMD_ADDR;
      jtag_pend     <= 1'b0;
      jrd           <= 1'b0;
      jaddr         <= '0;
      jwdata        <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (jtag_pend) begin
            if (jcmd == CMD_WRITE) begin
              jaddr         <= jaddr + 1'b1;
              monitor_ready <= 1'b1;
              jtag_pend     <= 1'b0;
            end else if (jtag_is_rd) begin
              state <= ST_JTAG_RD;
            end else begin
              monitor_ready <= 1'b1;
              jtag_pend     <= 1'b0;
            end
          end else if (read) begin
            state <= ST_CPU_RD;
          end
        end
        ST_JTAG_RD: begin
          MonDReg       <= ram_q;
          jaddr         <= jaddr + 1'b1;
          monitor_ready <= 1'b1;
          jtag_pend     <= 1'b0;
          state         <= ST_IDLE;
        end
        ST_CPU_RD: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // If several pulses coincide, the address load takes precedence.
      if (pulse_accept) begin
        jtag_pend     <= 1'b1;
        monitor_ready <= 1'b0;
        if (take_action_ocimem_a) begin
          jcmd  <= CMD_ADDR;
          jaddr <= jdo[ADDR_W+16:17];
          jrd   <= jdo[35];
        end else if (take_no_action_ocimem_a) begin
          jcmd <= CMD_CONT;
        end else begin
          jcmd   <= CMD_WRITE;
          jwdata <= jdo[34:3];
        end
      end else if (pulse_any) begin
        monitor_error <= 1'b1;
      end
    end
  end

  // Avalon side.
  // A write completes in the same cycle it is granted. A read completes in
  // the CPU_RD cycle, with data straight from the RAM output register. Any
  // other cycle stalls, and so does the idle case with no request at all.
  always_comb begin
    readdata    = (state == ST_CPU_RD && !reset) ? ram_q : 32'h0;
    waitrequest = 1'b1;
    if (!reset) begin
      if (state == ST_CPU_RD && read)
        waitrequest = 1'b0;
      else if (cpu_go && write && !read)
        waitrequest = 1'b0;
    end
  end

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// tb_nios2_debug_ocimem_ctrl
//
// Directed testbench for nios2_debug_ocimem_ctrl. Stimulus is a linear
// sequence of JTAG pulses and CPU Avalon transactions. Every expected value
// is hand-computed and checked with an immediate assertion.
module tb_nios2_debug_ocimem_ctrl;

  localparam int ADDR_W = 8;
  localparam int WAIT_LIMIT = 20;

  localparam logic [1:0] K_A   = 2'd0;
  localparam logic [1:0] K_NOA = 2'd1;
  localparam logic [1:0] K_B   = 2'd2;

  logic              clk;
  logic              reset;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [37:0]       jdo;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              debugaccess;
  logic [31:0]       readdata;
  logic              waitrequest;

  int checks;
  int errors;
  int waits;
  logic [31:0] rdata;

  nios2_debug_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .jdo                     (jdo),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case something stalls outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] a);
    logic [37:0] v;
    v = '0;
    v[35] = rd;
    v[24:17] = a;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  // One-cycle JTAG pulse. On return, the time is one step into the cycle
  // after the pulse.
  task automatic applyStimulus(input logic [1:0] kind, input logic [37:0] payload);
    jdo = payload;
    take_action_ocimem_a    = (kind == K_A);
    take_no_action_ocimem_a = (kind == K_NOA);
    take_action_ocimem_b    = (kind == K_B);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg, output int nwait);
    address = a; writedata = d; byteenable = be; debugaccess = dbg; write = 1'b1;
    nwait = 0;
    @(negedge clk);
    while (waitrequest && nwait < WAIT_LIMIT) begin
      nwait++;
      @(negedge clk);
    end
    tick();
    write = 1'b0; debugaccess = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output int nwait, output logic [31:0] d);
    address = a; read = 1'b1;
    nwait = 0;
    @(negedge clk);
    while (waitrequest && nwait < WAIT_LIMIT) begin
      nwait++;
      @(negedge clk);
    end
    d = readdata;
    tick();
    read = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    jdo = '0; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = '0; debugaccess = 1'b0;

    // Reset state, observed while reset is still high.
    tick(); tick();
    @(negedge clk);
    checkOutput("rst_waitrequest", {31'd0, waitrequest}, 32'd1);
    checkOutput("rst_MonDReg", MonDReg, 32'h0);
    checkOutput("rst_ready", {31'd0, monitor_ready}, 32'd0);
    checkOutput("rst_error", {31'd0, monitor_error}, 32'd0);
    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_jaddr", {24'd0, dut.jaddr}, 32'h0);
    tick();
    reset = 1'b0;

    // Preload ram[0x10] through JTAG: an address-only load, then a write.
    applyStimulus(K_A, jdo_a(1'b0, 8'h10));
    tick();
    applyStimulus(K_B, jdo_b(32'hDEADBEEF));
    checkOutput("wr_ready_cleared", {31'd0, monitor_ready}, 32'd0);
    tick();
    checkOutput("wr_ready_n2", {31'd0, monitor_ready}, 32'd1);
    checkOutput("wr_jaddr_inc", {24'd0, dut.jaddr}, 32'h11);

    // JTAG read at 0x10: data and ready at N+3, not at N+2.
    applyStimulus(K_A, jdo_a(1'b1, 8'h10));
    tick();
    checkOutput("rd_ready_n2", {31'd0, monitor_ready}, 32'd0);
    tick();
    checkOutput("rd_MonDReg_n3", MonDReg, 32'hDEADBEEF);
    checkOutput("rd_ready_n3", {31'd0, monitor_ready}, 32'd1);
    checkOutput("rd_jaddr", {24'd0, dut.jaddr}, 32'h11);

    // Burst of two writes starting at 0xFF, so the address wraps to 0x00.
    applyStimulus(K_A, jdo_a(1'b0, 8'hFF));
    tick();
    applyStimulus(K_B, jdo_b(32'h11111111));
    tick();
    applyStimulus(K_B, jdo_b(32'h22222222));
    tick();
    checkOutput("burst_jaddr_wrap", {24'd0, dut.jaddr}, 32'h01);
    applyStimulus(K_A, jdo_a(1'b1, 8'hFF));
    tick(); tick();
    checkOutput("burst_rd_ff", MonDReg, 32'h11111111);
    checkOutput("burst_jaddr_after_ff", {24'd0, dut.jaddr}, 32'h00);
    applyStimulus(K_NOA, '0);
    tick(); tick();
    checkOutput("burst_rd_00_cont", MonDReg, 32'h22222222);
    checkOutput("burst_jaddr_after_00", {24'd0, dut.jaddr}, 32'h01);

    // CPU byte-lane write, then read back. Then a write without
    // debugaccess, which must leave the RAM unchanged.
    cpu_write(8'h20, 32'h00000000, 4'hF, 1'b1, waits);
    checkOutput("cpu_wr_clear_wait", waits, 0);
    cpu_write(8'h20, 32'hAABBCCDD, 4'b0101, 1'b1, waits);
    checkOutput("cpu_wr_be_wait", waits, 0);
    cpu_read(8'h20, waits, rdata);
    checkOutput("cpu_rd_wait", waits, 1);
    checkOutput("cpu_rd_data", rdata, 32'h00BB00DD);
    cpu_write(8'h20, 32'h11223344, 4'hF, 1'b0, waits);
    checkOutput("cpu_wr_nodbg_wait", waits, 0);
    cpu_read(8'h20, waits, rdata);
    checkOutput("cpu_rd_nodbg_data", rdata, 32'h00BB00DD);

    // Collision: the CPU read starts in the cycle jtag_pend rises for a
    // JTAG read. The JTAG read goes first, and the CPU stalls for 3 cycles.
    applyStimulus(K_A, jdo_a(1'b1, 8'h10));
    cpu_read(8'h20, waits, rdata);
    checkOutput("coll_cpu_wait", waits, 3);
    checkOutput("coll_cpu_data", rdata, 32'h00BB00DD);
    checkOutput("coll_MonDReg", MonDReg, 32'hDEADBEEF);
    checkOutput("coll_ready", {31'd0, monitor_ready}, 32'd1);

    // Overflow: a second pulse one cycle after the first is dropped. If the
    // dropped write had run, jaddr would have advanced to 0x31.
    applyStimulus(K_A, jdo_a(1'b0, 8'h30));
    applyStimulus(K_B, jdo_b(32'h55555555));
    checkOutput("ovf_error", {31'd0, monitor_error}, 32'd1);
    checkOutput("ovf_jaddr_unchanged", {24'd0, dut.jaddr}, 32'h30);
    applyStimulus(K_A, jdo_a(1'b1, 8'h20));
    tick(); tick();
    checkOutput("ovf_good_cmd_data", MonDReg, 32'h00BB00DD);
    checkOutput("ovf_error_sticky", {31'd0, monitor_error}, 32'd1);

    // Reset in the JTAG_RD cycle, with a CPU write also held during reset.
    applyStimulus(K_A, jdo_a(1'b1, 8'h10));
    tick();
    reset = 1'b1;
    address = 8'h20; writedata = 32'hFFFFFFFF; byteenable = 4'hF; debugaccess = 1'b1; write = 1'b1;
    @(negedge clk);
    checkOutput("midrst_waitrequest", {31'd0, waitrequest}, 32'd1);
    tick();
    checkOutput("midrst_MonDReg", MonDReg, 32'h0);
    checkOutput("midrst_ready", {31'd0, monitor_ready}, 32'd0);
    checkOutput("midrst_jaddr", {24'd0, dut.jaddr}, 32'h0);
    checkOutput("midrst_error_cleared", {31'd0, monitor_error}, 32'd0);
    reset = 1'b0; write = 1'b0; debugaccess = 1'b0;
    tick();
    cpu_write(8'h40, 32'h12345678, 4'hF, 1'b1, waits);
    checkOutput("postrst_cpu_wr_wait", waits, 0);
    cpu_read(8'h20, waits, rdata);
    checkOutput("postrst_ram_kept", rdata, 32'h00BB00DD);
    cpu_read(8'h40, waits, rdata);
    checkOutput("postrst_rd_new", rdata, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
